spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
Parametrised full-duplex SPI shift engine, the next generation of the 8-bit mode-driven shift register.
- Loads a WIDTH-bit word through a valid/ready handshake and shifts it out MSB- or LSB-first on serial-clock edge strobes.
- Captures serialIn at the same time and presents the received word through a valid/ready handshake.
- Frame counting, abort and overrun detection are built in; sits between the SPI clock-edge generator and the host register interface.

Parameters:
WIDTH, 8, frame/shift-register width in bits (>=2)
CNT_W, $clog2(WIDTH), localparam, width of bitCount

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
shiftEdge  input  1  one-clk strobe marking a serial-clock sampling edge
lsbFirst  input  1  bit order: 1 = LSB-first, 0 = MSB-first; sampled at load
txData  input  WIDTH  word to transmit
txValid  input  1  txData valid
txReady  output  1  engine accepts txData this cycle
serialIn  input  1  serial data in (MISO/MOSI side dependent)
serialOut  output  1  serial data out
rxData  output  WIDTH  last received word
rxValid  output  1  rxData holds an unread word
rxReady  input  1  consumer takes rxData this cycle
busy  output  1  frame in progress
bitCount  output  CNT_W  shifts completed in the current frame
overrun  output  1  sticky: a frame completed while rxValid=1 and rxReady=0
overrunClr  input  1  clears overrun
abort  input  1  synchronous frame abort

Behaviour:
- Reset (async, rst_n=0): state IDLE, shreg=0, order reg=0, bitCount=0, rxData=0, rxValid=0, overrun=0, busy=0, serialOut=0, txReady=1. txValid is ignored while rst_n=0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - txReady=1.
  - txValid&&txReady at posedge: shreg<=txData, order<=lsbFirst, bitCount<=0, go to SHIFT.
  - shiftEdge is ignored.
- SHIFT:
  - busy=1. Without the optional feature, txReady=0.
  - Each shiftEdge:
    - MSB-first: shreg<={shreg[W-2:0],serialIn}.
    - LSB-first: shreg<={serialIn,shreg[W-1:1]}.
    - bitCount increments.
- serialOut:
  - Combinational.
  - MSB-first: shreg[W-1]. LSB-first: shreg[0].
  - Valid from the cycle after load. In IDLE it keeps the last value.
- Frame end:
  - Trigger: shiftEdge with bitCount==WIDTH-1.
  - Same posedge: rxData<=the shifted shreg value, rxValid<=1, bitCount<=0, state<=IDLE (or reload, see feature).
  - Latency: rxValid rises 1 clk after the final shiftEdge cycle.
- rxValid clears on rxValid&&rxReady.
  - A frame ending in that same cycle: new word loads, rxValid stays 1, no overrun.
- Overrun:
  - Frame end with rxValid=1 and rxReady=0: rxData is overwritten and overrun<=1.
  - Same-cycle set and overrunClr: set wins.
- abort in SHIFT:
  - Next state IDLE, bitCount<=0.
  - No rxValid and no rxData update.
  - shreg is retained.
  - abort has priority over a coincident final shiftEdge.
  - txReady=0 in any cycle where abort=1.
- Reset mid-frame: immediate return to reset values. No partial rxValid.
- shiftEdge spacing may be 1 clk (back-to-back strobes are legal).

Optional Feature:
SPI_SHIFT_DOUBLE_BUFFER_EN
- Defined:
  - One-entry tx holding buffer. txReady=1 whenever the buffer is empty, including during SHIFT.
  - At frame end with the buffer full: shreg loads the buffered word and its latched order in the same posedge, state stays SHIFT, buffer empties. There is no idle cycle between frames.
  - abort flushes the buffer.
- Undefined: no buffer. txReady=1 only in IDLE; frames are separated by at least 1 IDLE cycle.

Decomposition:
- Shared header/package spi_defs:
  - Bit-order constants MSB_FIRST/LSB_FIRST.
  - FSM state encoding IDLE/SHIFT.
  - Existing PLOAD/HOLD/LEFT/RIGHT mode defines kept alongside.
- One natural sub-module: spi_tx_buffer, the holding register with valid/ready. It is instantiated only under SPI_SHIFT_DOUBLE_BUFFER_EN.

Test Plan (WIDTH=8):
1. MSB-first exchange: load 8'hA5, serialIn stream 0,0,1,1,1,1,0,0 over 8 strobes -> serialOut 1,0,1,0,0,1,0,1; rxData=8'h3C; rxValid rises 1 clk after the 8th strobe; busy drops; bitCount=0.
2. LSB-first: load 8'h01, serialIn 0×7 then 1 -> first serialOut=1 then seven 0; rxData=8'h80.
3. Overrun: two frames with rxReady=0 -> second rxData overwrites and overrun=1. overrunClr pulse -> 0. Repeat with rxReady=1 on the completion cycle -> no overrun.
4. Abort after 3 strobes -> IDLE next clk, bitCount=0, rxValid stays 0, txReady=1. A new 8'hFF frame completes normally.
5. Reset asserted mid-frame (bitCount=5) -> all outputs at reset values asynchronously. After release, a full frame works.
6. With SPI_SHIFT_DOUBLE_BUFFER_EN: queue 8'h12 during a frame of 8'h34 -> serialOut continues into 8'h12's MSB on the strobe after the 8th with no IDLE cycle; txReady=0 while the buffer is full.

Source files
------------

// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: bit-order constants, FSM encoding
// and the legacy shift-register mode codes.
package spi_shift_engine_pkg;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Mode codes of the original 8-bit mode-driven shift register.
  typedef enum logic [1:0] {
    PLOAD = 2'b00,
    HOLD  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } mode_t;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Host/edge-generator facing bundle of the SPI shift engine.
// master = host side, slave = engine side.
interface spi_shift_engine_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             shiftEdge;
  logic             lsbFirst;
  logic [WIDTH-1:0] txData;
  logic             txValid;
  logic             txReady;
  logic             serialIn;
  logic             serialOut;
  logic [WIDTH-1:0] rxData;
  logic             rxValid;
  logic             rxReady;
  logic             busy;
  logic [CNT_W-1:0] bitCount;
  logic             overrun;
  logic             overrunClr;
  logic             abort;

  modport master (
    output shiftEdge, lsbFirst, txData, txValid, serialIn, rxReady, overrunClr, abort,
    input  txReady, serialOut, rxData, rxValid, busy, bitCount, overrun
  );

  modport slave (
    input  shiftEdge, lsbFirst, txData, txValid, serialIn, rxReady, overrunClr, abort,
    output txReady, serialOut, rxData, rxValid, busy, bitCount, overrun
  );

endinterface

// File: rtl/spi_shift_engine_tx_buffer.sv
// One-entry transmit holding register (word + bit order), used by the engine
// only when SPI_SHIFT_DOUBLE_BUFFER_EN is defined.
module spi_shift_engine_tx_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_order,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic             o_order
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             r_order;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_data  <= '0;
      r_order <= 1'b0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_full  <= 1'b1;
      r_data  <= i_data;
      r_order <= i_order;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_data  = r_data;
  assign o_order = r_order;

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: parallel load, serial shift on edge strobes,
// received-word handshake, overrun and abort. Optional SPI_SHIFT_DOUBLE_BUFFER_EN.
import spi_shift_engine_pkg::*;

module spi_shift_engine #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  spi_shift_engine_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_order;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_shifted;
  logic             w_edge;
  logic             w_frame_end;
  logic             w_reload;
  logic [WIDTH-1:0] w_reload_data;
  logic             w_reload_order;

  assign w_shifted = (r_order == MSB_FIRST) ? {r_shreg[WIDTH-2:0], bus.serialIn}
                                            : {bus.serialIn, r_shreg[WIDTH-1:1]};

  assign w_edge      = (r_state == SHIFT) && bus.shiftEdge && !bus.abort;
  assign w_frame_end = w_edge && (r_bit_cnt == LAST_BIT);

`ifdef SPI_SHIFT_DOUBLE_BUFFER_EN
  logic             w_buf_full;
  logic [WIDTH-1:0] w_buf_data;
  logic             w_buf_order;
  logic             w_accept_shift;
  logic             w_buf_wr;
  logic             w_buf_pop;

  // A word offered on the very frame-end cycle with an empty buffer bypasses
  // the buffer straight into the shift register.
  assign w_accept_shift = (r_state == SHIFT) && bus.txValid && bus.txReady;
  assign w_buf_wr       = w_accept_shift && !w_frame_end;
  assign w_buf_pop      = w_frame_end && w_buf_full;
  assign w_reload       = w_frame_end && (w_buf_full || w_accept_shift);
  assign w_reload_data  = w_buf_full ? w_buf_data  : bus.txData;
  assign w_reload_order = w_buf_full ? w_buf_order : bus.lsbFirst;
  assign bus.txReady    = !bus.abort && !w_buf_full;

  spi_shift_engine_tx_buffer #(.WIDTH(WIDTH)) u_tx_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_buf_wr),
    .i_data  (bus.txData),
    .i_order (bus.lsbFirst),
    .i_pop   (w_buf_pop),
    .i_flush (bus.abort),
    .o_full  (w_buf_full),
    .o_data  (w_buf_data),
    .o_order (w_buf_order)
  );
`else
  assign w_reload       = 1'b0;
  assign w_reload_data  = bus.txData;
  assign w_reload_order = bus.lsbFirst;
  assign bus.txReady    = (r_state == IDLE) && !bus.abort;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_order    <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_rx_valid && bus.rxReady) r_rx_valid <= 1'b0;
      if (bus.overrunClr)            r_overrun  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.txValid && bus.txReady) begin
            r_shreg   <= bus.txData;
            r_order   <= bus.lsbFirst;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
          end else if (w_frame_end) begin
            // Later assignments override the clears above: set beats clear.
            r_rx_data  <= w_shifted;
            r_rx_valid <= 1'b1;
            r_bit_cnt  <= '0;
            if (r_rx_valid && !bus.rxReady) r_overrun <= 1'b1;
            if (w_reload) begin
              r_shreg <= w_reload_data;
              r_order <= w_reload_order;
            end else begin
              r_shreg <= w_shifted;
              r_state <= IDLE;
            end
          end else if (w_edge) begin
            r_shreg   <= w_shifted;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.serialOut = (r_order == MSB_FIRST) ? r_shreg[WIDTH-1] : r_shreg[0];
  assign bus.busy      = (r_state == SHIFT);
  assign bus.bitCount  = r_bit_cnt;
  assign bus.rxData    = r_rx_data;
  assign bus.rxValid   = r_rx_valid;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine (WIDTH=8); the double-buffer scenario
// runs only when SPI_SHIFT_DOUBLE_BUFFER_EN is defined.
module tb_spi_shift_engine;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_shift_engine_if #(.WIDTH(WIDTH)) bus ();

  spi_shift_engine #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: i-th transmitted bit and assembled received word.
  function automatic logic model_tx_bit(input logic [7:0] tx, input logic lsb, input int i);
    return lsb ? tx[i] : tx[7-i];
  endfunction

  function automatic logic [7:0] model_tx_seq(input logic [7:0] tx, input logic lsb);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = model_tx_bit(tx, lsb, i);
    return s;
  endfunction

  function automatic logic [7:0] model_rx(input logic [7:0] sin, input logic lsb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (lsb) r[i] = sin[i];
      else     r[7-i] = sin[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] tx, input logic lsb, output bit timed_out);
    int t = 0;
    while (bus.txReady !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    timed_out    = (t >= 50);
    bus.txData   = tx;
    bus.lsbFirst = lsb;
    bus.txValid  = 1'b1;
    tick();
    bus.txValid  = 1'b0;
  endtask

  task automatic strobe(input logic sin);
    bus.serialIn  = sin;
    bus.shiftEdge = 1'b1;
    tick();
    bus.shiftEdge = 1'b0;
  endtask

  // Runs one complete frame; records serialOut before each strobe and bitCount after it.
  task automatic drive_frame(input logic [7:0] tx, input logic lsb, input logic [7:0] sin,
                             input int max_gap, input bit rdy_last, input bit clr_last,
                             output logic [7:0] so, output logic [7:0][CNT_W-1:0] bcs,
                             output logic rxv_before, output bit timed_out);
    start_frame(tx, lsb, timed_out);
    for (int i = 0; i < 8; i++) begin
      so[i] = bus.serialOut;
      if (i == 7) begin
        rxv_before     = bus.rxValid;
        bus.rxReady    = rdy_last;
        bus.overrunClr = clr_last;
      end
      strobe(sin[i]);
      bus.rxReady    = 1'b0;
      bus.overrunClr = 1'b0;
      bcs[i] = bus.bitCount;
      if (i < 7) repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  task automatic consume();
    bus.rxReady = 1'b1;
    tick();
    bus.rxReady = 1'b0;
  endtask

  task automatic test_reset();
    bus.txValid = 1'b1;
    bus.txData  = 8'h5A;
    #1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.txReady !== 1'b1) $display("FAIL reset_txReady got=%b exp=1", bus.txReady); else n_pass++;
    n_total++; if (bus.bitCount !== '0) $display("FAIL reset_bitCount got=%0d exp=0", bus.bitCount); else n_pass++;
    n_total++; if ({bus.rxValid, bus.overrun, bus.serialOut} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.rxValid, bus.overrun, bus.serialOut}); else n_pass++;
    n_total++; if (bus.rxData !== 8'h00) $display("FAIL reset_rxData got=%h exp=00", bus.rxData); else n_pass++;
    bus.txValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_msb_exchange();
    logic [7:0] so, sin;
    logic [7:0][CNT_W-1:0] bcs;
    logic rxv_before;
    bit to;
    sin = 8'b0011_1100;
    drive_frame(8'hA5, 1'b0, sin, 0, 1'b0, 1'b0, so, bcs, rxv_before, to);
    n_total++; if (to) $display("FAIL msb_load_timeout got=timeout exp=txReady"); else n_pass++;
    n_total++; if (so !== model_tx_seq(8'hA5, 1'b0)) $display("FAIL msb_serialOut got=%b exp=%b", so, model_tx_seq(8'hA5, 1'b0)); else n_pass++;
    n_total++; if (rxv_before !== 1'b0) $display("FAIL msb_rxValid_early got=%b exp=0", rxv_before); else n_pass++;
    n_total++; if (bus.rxValid !== 1'b1) $display("FAIL msb_rxValid got=%b exp=1", bus.rxValid); else n_pass++;
    n_total++; if (bus.rxData !== 8'h3C) $display("FAIL msb_rxData got=%h exp=3c", bus.rxData); else n_pass++;
    n_total++; if (bus.busy !== 1'b0 || bus.bitCount !== '0)
      $display("FAIL msb_idle got=busy%b/cnt%0d exp=busy0/cnt0", bus.busy, bus.bitCount); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++; if (bcs[i] !== CNT_W'(i + 1)) $display("FAIL msb_bitCount[%0d] got=%0d exp=%0d", i, bcs[i], i + 1); else n_pass++;
    end
    consume();
    n_total++; if (bus.rxValid !== 1'b0) $display("FAIL msb_rx_consumed got=%b exp=0", bus.rxValid); else n_pass++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] so;
    logic [7:0][CNT_W-1:0] bcs;
    logic rxv_before;
    bit to;
    drive_frame(8'h01, 1'b1, 8'h80, 1, 1'b0, 1'b0, so, bcs, rxv_before, to);
    n_total++; if (so !== 8'b0000_0001) $display("FAIL lsb_serialOut got=%b exp=00000001", so); else n_pass++;
    n_total++; if (bus.rxData !== 8'h80) $display("FAIL lsb_rxData got=%h exp=80", bus.rxData); else n_pass++;
    consume();
  endtask

  task automatic test_overrun();
    logic [7:0] so, tx, sin;
    logic lsb, rxv_before;
    logic [7:0][CNT_W-1:0] bcs;
    bit to;
    for (int f = 0; f < 4; f++) begin
      tx  = 8'($urandom());
      sin = 8'($urandom());
      lsb = 1'($urandom());
      drive_frame(tx, lsb, sin, 1, (f == 2), (f == 3), so, bcs, rxv_before, to);
      n_total++; if (bus.rxData !== model_rx(sin, lsb)) $display("FAIL ovr_rxData[%0d] got=%h exp=%h", f, bus.rxData, model_rx(sin, lsb)); else n_pass++;
      n_total++; if (bus.rxValid !== 1'b1) $display("FAIL ovr_rxValid[%0d] got=%b exp=1", f, bus.rxValid); else n_pass++;
      if (f == 0) begin
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_first got=%b exp=0", bus.overrun); else n_pass++;
      end else if (f == 1) begin
        n_total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", bus.overrun); else n_pass++;
        bus.overrunClr = 1'b1;
        tick();
        bus.overrunClr = 1'b0;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clear got=%b exp=0", bus.overrun); else n_pass++;
      end else if (f == 2) begin
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_ready_same_cycle got=%b exp=0", bus.overrun); else n_pass++;
      end else begin
        n_total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set_beats_clr got=%b exp=1", bus.overrun); else n_pass++;
      end
    end
    bus.overrunClr = 1'b1;
    consume();
    bus.overrunClr = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] so, sin, prev_rx;
    logic [7:0][CNT_W-1:0] bcs;
    logic rxv_before;
    bit to;
    start_frame(8'h6B, 1'b0, to);
    repeat (3) strobe(1'($urandom()));
    bus.abort = 1'b1;
    #1;
    n_total++; if (bus.txReady !== 1'b0) $display("FAIL abort_txReady_during got=%b exp=0", bus.txReady); else n_pass++;
    tick();
    bus.abort = 1'b0;
    #1;
    n_total++; if (bus.busy !== 1'b0 || bus.bitCount !== '0)
      $display("FAIL abort_idle got=busy%b/cnt%0d exp=busy0/cnt0", bus.busy, bus.bitCount); else n_pass++;
    n_total++; if (bus.rxValid !== 1'b0) $display("FAIL abort_rxValid got=%b exp=0", bus.rxValid); else n_pass++;
    n_total++; if (bus.txReady !== 1'b1) $display("FAIL abort_txReady_after got=%b exp=1", bus.txReady); else n_pass++;
    sin = 8'($urandom_range(255, 1));
    drive_frame(8'hFF, 1'b0, sin, 0, 1'b0, 1'b0, so, bcs, rxv_before, to);
    n_total++; if (so !== 8'hFF) $display("FAIL abort_next_serialOut got=%b exp=11111111", so); else n_pass++;
    n_total++; if (bus.rxData !== model_rx(sin, 1'b0)) $display("FAIL abort_next_rxData got=%h exp=%h", bus.rxData, model_rx(sin, 1'b0)); else n_pass++;
    consume();
    prev_rx = model_rx(sin, 1'b0);
    // Abort coinciding with the final strobe wins over frame completion.
    start_frame(8'h3D, 1'b1, to);
    repeat (7) strobe(1'($urandom()));
    bus.abort = 1'b1;
    strobe(1'b1);
    bus.abort = 1'b0;
    n_total++; if (bus.rxValid !== 1'b0 || bus.rxData !== prev_rx)
      $display("FAIL abort_final_edge got=v%b/%h exp=v0/%h", bus.rxValid, bus.rxData, prev_rx); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_final_busy got=%b exp=0", bus.busy); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] so, sin;
    logic [7:0][CNT_W-1:0] bcs;
    logic rxv_before;
    bit to;
    start_frame(8'hC3, 1'b0, to);
    repeat (5) strobe(1'($urandom()));
    n_total++; if (bus.bitCount !== CNT_W'(5)) $display("FAIL rstmid_bitCount got=%0d exp=5", bus.bitCount); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.busy !== 1'b0 || bus.bitCount !== '0 || bus.txReady !== 1'b1)
      $display("FAIL rstmid_ctrl got=busy%b/cnt%0d/rdy%b exp=busy0/cnt0/rdy1", bus.busy, bus.bitCount, bus.txReady); else n_pass++;
    n_total++; if (bus.rxData !== 8'h00 || {bus.rxValid, bus.overrun, bus.serialOut} !== 3'b000)
      $display("FAIL rstmid_data got=%h/%b exp=00/000", bus.rxData, {bus.rxValid, bus.overrun, bus.serialOut}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sin = 8'($urandom());
    drive_frame(8'h96, 1'b1, sin, 1, 1'b0, 1'b0, so, bcs, rxv_before, to);
    n_total++; if (so !== model_tx_seq(8'h96, 1'b1)) $display("FAIL rstmid_serialOut got=%b exp=%b", so, model_tx_seq(8'h96, 1'b1)); else n_pass++;
    n_total++; if (bus.rxData !== model_rx(sin, 1'b1)) $display("FAIL rstmid_rxData got=%h exp=%h", bus.rxData, model_rx(sin, 1'b1)); else n_pass++;
    consume();
  endtask

  task automatic test_random_frames();
    logic [7:0] so, tx, sin;
    logic lsb, rxv_before;
    logic [7:0][CNT_W-1:0] bcs;
    bit to;
    for (int f = 0; f < 25; f++) begin
      tx  = 8'($urandom());
      sin = 8'($urandom());
      lsb = 1'($urandom());
      drive_frame(tx, lsb, sin, 2, 1'b0, 1'b0, so, bcs, rxv_before, to);
      n_total++; if (to || so !== model_tx_seq(tx, lsb))
        $display("FAIL rand_serialOut[%0d] got=%b exp=%b timeout=%0d", f, so, model_tx_seq(tx, lsb), to); else n_pass++;
      n_total++; if (bus.rxData !== model_rx(sin, lsb) || bus.rxValid !== 1'b1)
        $display("FAIL rand_rx[%0d] got=%h/v%b exp=%h/v1", f, bus.rxData, bus.rxValid, model_rx(sin, lsb)); else n_pass++;
      consume();
      repeat ($urandom_range(2, 0)) tick();
    end
  endtask

`ifdef SPI_SHIFT_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    logic [7:0] so, sin1, sin2;
    bit to;
    sin1 = 8'($urandom());
    sin2 = 8'($urandom());
    start_frame(8'h34, 1'b0, to);
    strobe(sin1[0]);
    strobe(sin1[1]);
    n_total++; if (bus.txReady !== 1'b1) $display("FAIL db_txReady_empty got=%b exp=1", bus.txReady); else n_pass++;
    bus.txData   = 8'h12;
    bus.lsbFirst = 1'b0;
    bus.txValid  = 1'b1;
    tick();
    bus.txValid  = 1'b0;
    n_total++; if (bus.txReady !== 1'b0) $display("FAIL db_txReady_full got=%b exp=0", bus.txReady); else n_pass++;
    for (int i = 2; i < 8; i++) strobe(sin1[i]);
    n_total++; if (bus.busy !== 1'b1 || bus.bitCount !== '0)
      $display("FAIL db_no_idle got=busy%b/cnt%0d exp=busy1/cnt0", bus.busy, bus.bitCount); else n_pass++;
    n_total++; if (bus.rxData !== model_rx(sin1, 1'b0) || bus.rxValid !== 1'b1)
      $display("FAIL db_rx1 got=%h/v%b exp=%h/v1", bus.rxData, bus.rxValid, model_rx(sin1, 1'b0)); else n_pass++;
    n_total++; if (bus.txReady !== 1'b1) $display("FAIL db_txReady_drained got=%b exp=1", bus.txReady); else n_pass++;
    consume();
    for (int i = 0; i < 8; i++) begin
      so[i] = bus.serialOut;
      strobe(sin2[i]);
    end
    n_total++; if (so !== model_tx_seq(8'h12, 1'b0)) $display("FAIL db_serialOut got=%b exp=%b", so, model_tx_seq(8'h12, 1'b0)); else n_pass++;
    n_total++; if (bus.rxData !== model_rx(sin2, 1'b0) || bus.busy !== 1'b0)
      $display("FAIL db_rx2 got=%h/busy%b exp=%h/busy0", bus.rxData, bus.busy, model_rx(sin2, 1'b0)); else n_pass++;
    consume();
  endtask
`endif

  initial begin
    bus.shiftEdge  = 1'b0;
    bus.lsbFirst   = 1'b0;
    bus.txData     = '0;
    bus.txValid    = 1'b0;
    bus.serialIn   = 1'b0;
    bus.rxReady    = 1'b0;
    bus.overrunClr = 1'b0;
    bus.abort      = 1'b0;
    test_reset();
    test_msb_exchange();
    test_lsb_first();
    test_overrun();
    test_abort();
    test_reset_midframe();
    test_random_frames();
`ifdef SPI_SHIFT_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
